keypad_entry_buffer: RTL and testbench
======================================

Name: keypad_entry_buffer

Overview:
- Sits directly downstream of the keypad scanner. Consumes its registered 4-bit key code, in the same scanClock domain.
- Qualifies each change of key code as a new keystroke and shifts accepted decimal digits into a NUM_DIGITS-wide BCD entry register.
- An enter command latches the entry for downstream display/compute logic.
- Repeats of the same digit are indistinguishable at the scanner output, so they are not registered (intrinsic; documented).

Parameters:
- NUM_DIGITS, 4: BCD digits held in the entry register; legal range 1..8.
- STABLE_CYCLES, 3: consecutive scanClock cycles a new key code must hold before acceptance; legal range 1..255.
- COUNT_W, $clog2(NUM_DIGITS+1): width of digitCount. Derived; not overridden.

Ports:
- scanClock, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- key, input, 4: key code from the scanner. 0..9 = digit; 10..15 = non-digit.
- clearEntry, input, 1: synchronous clear of the entry, level-sampled each cycle.
- enterEntry, input, 1: synchronous latch-and-clear of the entry, level-sampled each cycle.
- entryDigits, output, 4*NUM_DIGITS: live BCD entry. Digit 0 in [3:0] is the most recent.
- digitCount, output, COUNT_W: number of valid digits, saturating at NUM_DIGITS.
- newDigit, output, 1: one-cycle pulse on the cycle after a digit is accepted.
- entryValue, output, 4*NUM_DIGITS: entry latched by enterEntry.
- entryValid, output, 1: one-cycle pulse on the cycle after entryValue updates.

Behaviour:
- Reset (async assert, sync release effect): all outputs 0, prevKey 0, candidate 0, stable counter 0, state SYNC.
- All other logic is registered on the scanClock rising edge.
- State SYNC (one cycle after reset): prevKey <= key; go to WAIT. This prevents a stale scanner value from being accepted as a keystroke.
- State WAIT:
  - if key != prevKey: candidate <= key, counter <= 1, go to QUALIFY;
  - if additionally STABLE_CYCLES == 1, go directly to ACCEPT.
- State QUALIFY:
  - if key != candidate: go to WAIT, prevKey unchanged (glitch rejected);
  - else counter++; when counter reaches STABLE_CYCLES, go to ACCEPT.
- State ACCEPT (one cycle): prevKey <= candidate; go to WAIT.
  - If candidate <= 9: entryDigits <= {entryDigits[4*NUM_DIGITS-5:0], candidate}, digitCount <= min(digitCount+1, NUM_DIGITS), newDigit pulses next cycle.
  - If candidate >= 10: prevKey updates, no shift, no pulse.
- Overflow: when digitCount == NUM_DIGITS, the oldest digit is shifted out (wrap); digitCount stays NUM_DIGITS.
- Latency: key change to newDigit = STABLE_CYCLES + 2 cycles (WAIT edge, STABLE_CYCLES-1 qualify edges, ACCEPT edge, pulse register).
- enterEntry (cycle N): entryValue <= entryDigits, entryDigits <= 0, digitCount <= 0, entryValid = 1 in cycle N+1.
  - Latches zero if digitCount == 0 (still pulses).
- clearEntry: entryDigits <= 0, digitCount <= 0. entryValue is untouched.
- Priority within one cycle: clearEntry > enterEntry > ACCEPT shift.
  - An ACCEPT coinciding with clear or enter is dropped for the entry (no shift, no newDigit), but prevKey still updates so that key is not re-accepted.
  - clear and enter together: clear only, no entryValid.
- Qualification FSM runs independently of clear/enter; only the shift is suppressed.
- Reset mid-QUALIFY or mid-ACCEPT: immediate return to reset values; the partial keystroke is lost.
- FSM encoding: 2-bit; unused code goes to SYNC.

Decomposition:
- Shared package keypad_pkg:
  - state enum {SYNC, WAIT, QUALIFY, ACCEPT};
  - KEY_W = 4; BCD_MAX = 9.
  - The scanner's digit-code constants, so scanner and buffer share one encoding.
- One natural sub-module, key_change_qualifier: the SYNC/WAIT/QUALIFY/ACCEPT FSM plus counter. Outputs acceptStrobe and acceptedKey.
- The shift register, clear/enter logic and output pulses stay in the top module.

Test Plan:
- Reset with key=5 held, then hold key=5 for 10 cycles -> no newDigit, digitCount=0.
- key: 5 -> 2 held 3 cycles, then 2 -> 7 held 3 cycles -> newDigit twice, entryDigits=0x0027, digitCount=2; each pulse 5 cycles after its key change.
- key 2 -> 8 for 2 cycles, then back to 2 (STABLE_CYCLES=3) -> no acceptance; entryDigits unchanged.
- Alternate keys 1,2,3,4,5 (each stable) -> entryDigits=0x2345, digitCount stays 4 after the 5th digit.
- Entry 0x0027, pulse enterEntry -> next cycle entryValid=1, entryValue=0x0027, entryDigits=0, digitCount=0.
- clearEntry and enterEntry asserted together on an ACCEPT cycle of key 9 -> entryDigits=0, no entryValid, no newDigit; key 9 held longer is not re-accepted.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad encodings: key code width, digit codes and the keystroke
// qualification states used by the scanner and the entry buffer.
package keypad_pkg;

   localparam int KEY_W   = 4;
   localparam int BCD_MAX = 9;

   localparam logic [KEY_W-1:0] KEY_0    = 4'd0;
   localparam logic [KEY_W-1:0] KEY_1    = 4'd1;
   localparam logic [KEY_W-1:0] KEY_2    = 4'd2;
   localparam logic [KEY_W-1:0] KEY_3    = 4'd3;
   localparam logic [KEY_W-1:0] KEY_4    = 4'd4;
   localparam logic [KEY_W-1:0] KEY_5    = 4'd5;
   localparam logic [KEY_W-1:0] KEY_6    = 4'd6;
   localparam logic [KEY_W-1:0] KEY_7    = 4'd7;
   localparam logic [KEY_W-1:0] KEY_8    = 4'd8;
   localparam logic [KEY_W-1:0] KEY_9    = 4'd9;
   localparam logic [KEY_W-1:0] KEY_STAR = 4'd10;
   localparam logic [KEY_W-1:0] KEY_HASH = 4'd11;

   typedef enum logic [1:0] {
      SYNC    = 2'd0,
      WAIT    = 2'd1,
      QUALIFY = 2'd2,
      ACCEPT  = 2'd3
   } state_t;

   function automatic logic is_digit(input logic [KEY_W-1:0] code);
      return (code <= KEY_W'(BCD_MAX));
   endfunction

endpackage

// File: rtl/keypad_entry_buffer_if.sv
// Key input, entry controls and entry outputs of the keypad entry buffer.
interface keypad_entry_buffer_if #(
   parameter int NUM_DIGITS = 4
);
   import keypad_pkg::*;

   localparam int COUNT_W = $clog2(NUM_DIGITS + 1);

   // No backpressure: newDigit and entryValid are single-cycle strobes that the
   // consumer must take when high; clearEntry/enterEntry are sampled every edge.
   logic [KEY_W-1:0]        key;
   logic                    clearEntry;
   logic                    enterEntry;
   logic [4*NUM_DIGITS-1:0] entryDigits;
   logic [COUNT_W-1:0]      digitCount;
   logic                    newDigit;
   logic [4*NUM_DIGITS-1:0] entryValue;
   logic                    entryValid;
   state_t                  qualState;

   modport master (
      output key, clearEntry, enterEntry,
      input  entryDigits, digitCount, newDigit, entryValue, entryValid, qualState
   );

   modport slave (
      input  key, clearEntry, enterEntry,
      output entryDigits, digitCount, newDigit, entryValue, entryValid, qualState
   );

endinterface

// File: rtl/key_change_qualifier.sv
// Turns changes of the scanner key code into single-cycle accept strobes once
// the new code has held for STABLE_CYCLES consecutive cycles.
module key_change_qualifier
   import keypad_pkg::*;
#(
   parameter int STABLE_CYCLES = 3
) (
   input  logic             scanClock,
   input  logic             reset,
   input  logic [KEY_W-1:0] key,
   output logic             acceptStrobe,
   output logic [KEY_W-1:0] acceptedKey,
   output state_t           state
);

   localparam int CNT_W = 8;

   state_t           state_q, state_d;
   logic [KEY_W-1:0] prev_key_q, prev_key_d;
   logic [KEY_W-1:0] cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge scanClock or posedge reset) begin
      if (reset) begin
         state_q    <= SYNC;
         prev_key_q <= '0;
         cand_q     <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         prev_key_q <= prev_key_d;
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      prev_key_d = prev_key_q;
      cand_d     = cand_q;
      cnt_d      = cnt_q;
      case (state_q)
         // Adopt whatever the scanner shows out of reset so it is never a keystroke.
         SYNC: begin
            prev_key_d = key;
            state_d    = WAIT;
         end
         WAIT: begin
            if (key != prev_key_q) begin
               cand_d  = key;
               cnt_d   = CNT_W'(1);
               state_d = (STABLE_CYCLES == 1) ? ACCEPT : QUALIFY;
            end
         end
         QUALIFY: begin
            if (key != cand_q) begin
               state_d = WAIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) state_d = ACCEPT;
            end
         end
         ACCEPT: begin
            prev_key_d = cand_q;
            state_d    = WAIT;
         end
         default: state_d = SYNC;
      endcase
   end

   assign acceptStrobe = (state_q == ACCEPT);
   assign acceptedKey  = cand_q;
   assign state        = state_q;

endmodule

// File: rtl/keypad_entry_buffer.sv
// BCD entry register fed by qualified keystrokes, with clear and enter
// (latch-and-clear) controls and one-cycle notification strobes.
module keypad_entry_buffer
   import keypad_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 3
) (
   input  logic scanClock,
   input  logic reset,
   keypad_entry_buffer_if.slave bus
);

   localparam int COUNT_W = $clog2(NUM_DIGITS + 1);
   localparam int ENTRY_W = 4 * NUM_DIGITS;

   logic               accept_strobe;
   logic [KEY_W-1:0]   accepted_key;
   state_t             qual_state;

   logic [ENTRY_W-1:0] digits_q;
   logic [COUNT_W-1:0] count_q;
   logic [ENTRY_W-1:0] value_q;
   logic               valid_q;
   logic               shifted_q;
   logic               new_digit_q;

   logic [ENTRY_W-1:0] digits_shifted;
   logic [COUNT_W-1:0] count_inc;
   logic               shift_en;

   key_change_qualifier #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_qualifier (
      .scanClock   (scanClock),
      .reset       (reset),
      .key         (bus.key),
      .acceptStrobe(accept_strobe),
      .acceptedKey (accepted_key),
      .state       (qual_state)
   );

   always_comb begin
      digits_shifted               = digits_q << KEY_W;
      digits_shifted[KEY_W-1:0]    = accepted_key;
      count_inc = (count_q == COUNT_W'(NUM_DIGITS)) ? count_q : count_q + COUNT_W'(1);
      // Clear and enter both win over a coinciding keystroke.
      shift_en  = accept_strobe && is_digit(accepted_key) && !bus.clearEntry && !bus.enterEntry;
   end

   always_ff @(posedge scanClock or posedge reset) begin
      if (reset) begin
         digits_q    <= '0;
         count_q     <= '0;
         value_q     <= '0;
         valid_q     <= 1'b0;
         shifted_q   <= 1'b0;
         new_digit_q <= 1'b0;
      end else begin
         valid_q     <= 1'b0;
         shifted_q   <= shift_en;
         new_digit_q <= shifted_q;
         if (bus.clearEntry) begin
            digits_q <= '0;
            count_q  <= '0;
         end else if (bus.enterEntry) begin
            value_q  <= digits_q;
            digits_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b1;
         end else if (shift_en) begin
            digits_q <= digits_shifted;
            count_q  <= count_inc;
         end
      end
   end

   assign bus.entryDigits = digits_q;
   assign bus.digitCount  = count_q;
   assign bus.newDigit    = new_digit_q;
   assign bus.entryValue  = value_q;
   assign bus.entryValid  = valid_q;
   assign bus.qualState   = qual_state;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Directed and randomized checks of keypad_entry_buffer (4 digits, 3-cycle qualify).
module tb_keypad_entry_buffer;
   import keypad_pkg::*;

   localparam int N = 4;
   localparam int S = 3;

   logic scanClock = 1'b0;
   logic reset;

   keypad_entry_buffer_if #(.NUM_DIGITS(N)) bus ();

   keypad_entry_buffer #(
      .NUM_DIGITS   (N),
      .STABLE_CYCLES(S)
   ) dut (
      .scanClock(scanClock),
      .reset    (reset),
      .bus      (bus.slave)
   );

   // Clock
   always #5 scanClock = ~scanClock;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference: digits most-recent-first, oldest dropped beyond N.
   logic [3:0] exp_q[$];
   logic [3:0] last_acc;
   logic [15:0] exp_value;

   function automatic logic [15:0] model_digits();
      logic [15:0] v = '0;
      for (int i = 0; i < exp_q.size(); i++) v = v | (16'(exp_q[i]) << (4 * i));
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge scanClock);
      #1;
   endtask

   // Drive a key and hold it; count newDigit pulses and note the edge of the last one.
   task automatic hold_key(input logic [3:0] k, input int hold, output int pulses, output int edge_at);
      bus.key = k;
      pulses  = 0;
      edge_at = 0;
      for (int i = 1; i <= hold; i++) begin
         tick();
         if (bus.newDigit === 1'b1) begin
            pulses++;
            edge_at = i;
         end
      end
   endtask

   task automatic press_expect(input logic [3:0] k, input int hold, input int exp_edge, input string tag);
      int p, e;
      hold_key(k, hold, p, e);
      check({tag, "_pulses"}, 32'(p), (exp_edge != 0) ? 32'd1 : 32'd0);
      if (exp_edge != 0) check({tag, "_latency"}, 32'(e), 32'(exp_edge));
   endtask

   task automatic pulse_enter();
      bus.enterEntry = 1'b1;
      tick();
      bus.enterEntry = 1'b0;
   endtask

   initial begin
      int p, e, valids;
      logic [3:0] cur, k, g;
      bit acc;

      reset          = 1'b1;
      bus.key        = 4'd5;
      bus.clearEntry = 1'b0;
      bus.enterEntry = 1'b0;
      repeat (3) tick();
      check("rst_digits", 32'(bus.entryDigits), 32'h0);
      check("rst_count",  32'(bus.digitCount),  32'h0);
      check("rst_newdig", 32'(bus.newDigit),    32'h0);
      check("rst_value",  32'(bus.entryValue),  32'h0);
      check("rst_valid",  32'(bus.entryValid),  32'h0);
      check("rst_state",  32'(bus.qualState),   32'(SYNC));
      reset = 1'b0;

      // Stale key present at reset release is not a keystroke.
      press_expect(4'd5, 10, 0, "stale5");
      check("stale5_count", 32'(bus.digitCount), 32'h0);

      press_expect(4'd2, 6, S + 2, "key2");
      press_expect(4'd7, 6, S + 2, "key7");
      check("d27_digits", 32'(bus.entryDigits), 32'h0027);
      check("d27_count",  32'(bus.digitCount),  32'd2);

      // Short excursion to 8 is rejected.
      press_expect(4'd8, 2, 0, "glitch8");
      press_expect(4'd7, 6, 0, "back7");
      check("glitch_digits", 32'(bus.entryDigits), 32'h0027);

      pulse_enter();
      check("enter_valid",  32'(bus.entryValid),  32'd1);
      check("enter_value",  32'(bus.entryValue),  32'h0027);
      check("enter_digits", 32'(bus.entryDigits), 32'h0);
      check("enter_count",  32'(bus.digitCount),  32'd0);
      tick();
      check("enter_valid_drop", 32'(bus.entryValid), 32'd0);

      for (int d = 1; d <= 5; d++) begin
         press_expect(4'(d), 6, S + 2, "seq");
         if (d == 4) begin
            check("seq4_digits", 32'(bus.entryDigits), 32'h1234);
            check("seq4_count",  32'(bus.digitCount),  32'd4);
         end
      end
      check("wrap_digits", 32'(bus.entryDigits), 32'h2345);
      check("wrap_count",  32'(bus.digitCount),  32'd4);

      // Clear and enter together on the ACCEPT cycle of key 9.
      hold_key(4'd9, S, p, e);
      check("k9_prepulse", 32'(p), 32'd0);
      check("k9_state", 32'(bus.qualState), 32'(ACCEPT));
      bus.clearEntry = 1'b1;
      bus.enterEntry = 1'b1;
      tick();
      bus.clearEntry = 1'b0;
      bus.enterEntry = 1'b0;
      check("ce_valid",  32'(bus.entryValid),  32'd0);
      check("ce_digits", 32'(bus.entryDigits), 32'h0);
      check("ce_count",  32'(bus.digitCount),  32'd0);
      check("ce_value",  32'(bus.entryValue),  32'h0027);
      valids = 0;
      p = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.newDigit === 1'b1) p++;
         if (bus.entryValid === 1'b1) valids++;
      end
      check("k9_no_reaccept", 32'(p), 32'd0);
      check("ce_no_valid",    32'(valids), 32'd0);
      check("k9_digits", 32'(bus.entryDigits), 32'h0);

      pulse_enter();
      check("enter0_valid", 32'(bus.entryValid), 32'd1);
      check("enter0_value", 32'(bus.entryValue), 32'h0);

      // Randomized runs: long runs are accepted only when they differ from the
      // last accepted key; runs shorter than S cycles never are.
      cur       = 4'd9;
      last_acc  = 4'd9;
      exp_value = 16'h0;
      exp_q.delete();
      for (int r = 0; r < 40; r++) begin
         if ($urandom_range(0, 2) == 0) begin
            do g = 4'($urandom_range(0, 15)); while (g == cur);
            hold_key(g, $urandom_range(1, S - 1), p, e);
            check("rnd_glitch_pulses", 32'(p), 32'd0);
            cur = g;
         end
         do k = 4'($urandom_range(0, 15)); while (k == cur);
         acc = (k != last_acc);
         if (acc) begin
            last_acc = k;
            if (k <= 4'd9) begin
               exp_q.push_front(k);
               if (exp_q.size() > N) void'(exp_q.pop_back());
            end
         end
         hold_key(k, $urandom_range(S + 3, S + 6), p, e);
         cur = k;
         check("rnd_pulses", 32'(p), (acc && k <= 4'd9) ? 32'd1 : 32'd0);
         check("rnd_digits", 32'(bus.entryDigits), 32'(model_digits()));
         check("rnd_count",  32'(bus.digitCount),  32'(exp_q.size()));
         if ($urandom_range(0, 3) == 0) begin
            exp_value = model_digits();
            exp_q.delete();
            pulse_enter();
            check("rnd_enter_valid", 32'(bus.entryValid), 32'd1);
            check("rnd_enter_value", 32'(bus.entryValue), 32'(exp_value));
            check("rnd_enter_count", 32'(bus.digitCount), 32'd0);
         end
      end
      check("rnd_final_value", 32'(bus.entryValue), 32'(exp_value));

      // Final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
